// File: rtl/ras_ckpt.sv
// Return-address stack with checkpoint/restore for speculative fetch.
// A circular array holds return addresses; ptr/cnt can be snapshotted and restored after a flush.
module ras_ckpt #(
  parameter int DEPTH = 8,
  parameter int VA_W  = 32,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [VA_W-1:0]  push_addr_i,
  input  logic             pop_i,
  input  logic             restore_i,
  input  logic [PTR_W-1:0] restore_ptr_i,
  input  logic [CNT_W-1:0] restore_cnt_i,
  input  logic [VA_W-1:0]  restore_top_i,
  output logic [VA_W-1:0]  top_o,
  output logic             top_valid_o,
  output logic [PTR_W-1:0] ckpt_ptr_o,
  output logic [CNT_W-1:0] ckpt_cnt_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  logic [VA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic [PTR_W-1:0] ptr_n;
  logic [CNT_W-1:0] cnt_n;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [VA_W-1:0]  wr_data;
  logic             ovf_n;
  logic             udf_n;
  logic             empty;
  logic             full;

  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] c);
    if (c > CNT_W'(DEPTH)) return CNT_W'(DEPTH);
    return c;
  endfunction

  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));

  // Request resolution: restore beats push/pop; an empty push+pop degenerates to push.
  always_comb begin
    ptr_n   = ptr;
    cnt_n   = cnt;
    wr_en   = 1'b0;
    wr_idx  = ptr;
    wr_data = push_addr_i;
    ovf_n   = 1'b0;
    udf_n   = 1'b0;
    if (restore_i) begin
      ptr_n   = restore_ptr_i;
      cnt_n   = clamp_cnt(restore_cnt_i);
      wr_en   = (cnt_n != '0);
      wr_idx  = restore_ptr_i;
      wr_data = restore_top_i;
    end else if (push_i && pop_i && !empty) begin
      wr_en  = 1'b1;
      wr_idx = ptr;
    end else if (push_i) begin
      ptr_n  = ptr + PTR_W'(1);
      wr_en  = 1'b1;
      wr_idx = ptr_n;
      if (full) ovf_n = 1'b1;
      else      cnt_n = cnt + CNT_W'(1);
    end else if (pop_i) begin
      if (empty) begin
        udf_n = 1'b1;
      end else begin
        ptr_n = ptr - PTR_W'(1);
        cnt_n = cnt - CNT_W'(1);
      end
    end
  end

  // State update; reset also clears the array so a restored stale pointer reads zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      cnt         <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ptr         <= ptr_n;
      cnt         <= cnt_n;
      overflow_o  <= ovf_n;
      underflow_o <= udf_n;
      if (wr_en) mem[wr_idx] <= wr_data;
    end
  end

  assign top_o       = mem[ptr];
  assign top_valid_o = !empty;
  assign ckpt_ptr_o  = ptr;
  assign ckpt_cnt_o  = cnt;

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt at DEPTH=4, VA_W=32.
module tb_ras_ckpt;
  localparam int DEPTH = 4;
  localparam int VA_W  = 32;
  localparam int PTR_W = 2;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             push_i;
  logic [VA_W-1:0]  push_addr_i;
  logic             pop_i;
  logic             restore_i;
  logic [PTR_W-1:0] restore_ptr_i;
  logic [CNT_W-1:0] restore_cnt_i;
  logic [VA_W-1:0]  restore_top_i;
  logic [VA_W-1:0]  top_o;
  logic             top_valid_o;
  logic [PTR_W-1:0] ckpt_ptr_o;
  logic [CNT_W-1:0] ckpt_cnt_o;
  logic             overflow_o;
  logic             underflow_o;

  int n_chk  = 0;
  int n_fail = 0;

  ras_ckpt #(.DEPTH(DEPTH), .VA_W(VA_W)) dut (
    .clk(clk), .rst(rst), .push_i(push_i), .push_addr_i(push_addr_i), .pop_i(pop_i),
    .restore_i(restore_i), .restore_ptr_i(restore_ptr_i), .restore_cnt_i(restore_cnt_i),
    .restore_top_i(restore_top_i), .top_o(top_o), .top_valid_o(top_valid_o),
    .ckpt_ptr_o(ckpt_ptr_o), .ckpt_cnt_o(ckpt_cnt_o), .overflow_o(overflow_o),
    .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; push_i = 1'b0; pop_i = 1'b0; restore_i = 1'b0;
    push_addr_i = '0; restore_ptr_i = '0; restore_cnt_i = '0; restore_top_i = '0;
  endtask

  task automatic do_push(input logic [VA_W-1:0] a);
    idle(); push_i = 1'b1; push_addr_i = a; step(); idle();
  endtask

  task automatic do_pop();
    idle(); pop_i = 1'b1; step(); idle();
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; step(); idle();
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; step(); step(); idle();
    n_chk++; if (top_o !== 32'h0) begin n_fail++; $display("FAIL reset_top: got %h want %h", top_o, 32'h0); end
    n_chk++; if (top_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", top_valid_o); end
    n_chk++; if (ckpt_ptr_o !== 2'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d want 0", ckpt_ptr_o); end
    n_chk++; if (ckpt_cnt_o !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", ckpt_cnt_o); end
    n_chk++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%b udf=%b want 0 0", overflow_o, underflow_o); end
  endtask

  task automatic test_push_pop();
    do_reset();
    do_push(32'h100);
    n_chk++; if (top_o !== 32'h100 || top_valid_o !== 1'b1) begin n_fail++; $display("FAIL push1: got top=%h valid=%b want 100 1", top_o, top_valid_o); end
    do_push(32'h200);
    do_push(32'h300);
    n_chk++; if (top_o !== 32'h300) begin n_fail++; $display("FAIL push3_top: got %h want %h", top_o, 32'h300); end
    n_chk++; if (ckpt_cnt_o !== 3'd3 || ckpt_ptr_o !== 2'd3) begin n_fail++; $display("FAIL push3_state: got cnt=%0d ptr=%0d want 3 3", ckpt_cnt_o, ckpt_ptr_o); end
    do_pop();
    n_chk++; if (top_o !== 32'h200) begin n_fail++; $display("FAIL pop1_top: got %h want %h", top_o, 32'h200); end
    do_pop();
    n_chk++; if (top_o !== 32'h100 || top_valid_o !== 1'b1 || ckpt_cnt_o !== 3'd1) begin n_fail++; $display("FAIL pop2: got top=%h valid=%b cnt=%0d want 100 1 1", top_o, top_valid_o, ckpt_cnt_o); end
    n_chk++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin n_fail++; $display("FAIL pop2_flags: got ovf=%b udf=%b want 0 0", overflow_o, underflow_o); end
  endtask

  task automatic test_overflow();
    logic [VA_W-1:0] exp_top [4];
    exp_top[0] = 32'h50; exp_top[1] = 32'h40; exp_top[2] = 32'h30; exp_top[3] = 32'h20;
    do_reset();
    do_push(32'h10); do_push(32'h20); do_push(32'h30); do_push(32'h40);
    n_chk++; if (overflow_o !== 1'b0 || ckpt_cnt_o !== 3'd4) begin n_fail++; $display("FAIL full_no_ovf: got ovf=%b cnt=%0d want 0 4", overflow_o, ckpt_cnt_o); end
    do_push(32'h50);
    n_chk++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b want 1", overflow_o); end
    n_chk++; if (ckpt_cnt_o !== 3'd4 || ckpt_ptr_o !== 2'd1) begin n_fail++; $display("FAIL ovf_state: got cnt=%0d ptr=%0d want 4 1", ckpt_cnt_o, ckpt_ptr_o); end
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (top_o !== exp_top[i]) begin n_fail++; $display("FAIL ovf_pop%0d_top: got %h want %h", i, top_o, exp_top[i]); end
      do_pop();
      if (i == 0) begin
        n_chk++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_single: got %b want 0", overflow_o); end
      end
    end
    n_chk++; if (ckpt_cnt_o !== 3'd0 || top_valid_o !== 1'b0 || underflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_drain: got cnt=%0d valid=%b udf=%b want 0 0 0", ckpt_cnt_o, top_valid_o, underflow_o); end
  endtask

  task automatic test_underflow();
    do_reset();
    do_pop();
    n_chk++; if (underflow_o !== 1'b1) begin n_fail++; $display("FAIL udf_pulse: got %b want 1", underflow_o); end
    n_chk++; if (ckpt_ptr_o !== 2'd0 || ckpt_cnt_o !== 3'd0) begin n_fail++; $display("FAIL udf_state: got ptr=%0d cnt=%0d want 0 0", ckpt_ptr_o, ckpt_cnt_o); end
    step();
    n_chk++; if (underflow_o !== 1'b0) begin n_fail++; $display("FAIL udf_single: got %b want 0", underflow_o); end
  endtask

  task automatic test_restore();
    logic [PTR_W-1:0] sv_ptr;
    logic [CNT_W-1:0] sv_cnt;
    logic [VA_W-1:0]  sv_top;
    do_reset();
    do_push(32'hA0);
    sv_ptr = ckpt_ptr_o; sv_cnt = ckpt_cnt_o; sv_top = top_o;
    n_chk++; if (sv_ptr !== 2'd1 || sv_cnt !== 3'd1 || sv_top !== 32'hA0) begin n_fail++; $display("FAIL ckpt_rec: got ptr=%0d cnt=%0d top=%h want 1 1 a0", sv_ptr, sv_cnt, sv_top); end
    do_pop();
    do_push(32'hB0);
    do_push(32'hC0);
    n_chk++; if (top_o !== 32'hC0 || ckpt_cnt_o !== 3'd2) begin n_fail++; $display("FAIL pre_restore: got top=%h cnt=%0d want c0 2", top_o, ckpt_cnt_o); end
    idle(); restore_i = 1'b1; restore_ptr_i = sv_ptr; restore_cnt_i = sv_cnt; restore_top_i = sv_top;
    push_i = 1'b1; push_addr_i = 32'hEE; step(); idle();
    n_chk++; if (top_o !== 32'hA0 || ckpt_cnt_o !== 3'd1 || ckpt_ptr_o !== 2'd1) begin n_fail++; $display("FAIL restore: got top=%h cnt=%0d ptr=%0d want a0 1 1", top_o, ckpt_cnt_o, ckpt_ptr_o); end
    n_chk++; if (overflow_o !== 1'b0 || underflow_o !== 1'b0) begin n_fail++; $display("FAIL restore_flags: got ovf=%b udf=%b want 0 0", overflow_o, underflow_o); end
  endtask

  task automatic test_push_pop_same();
    do_reset();
    do_push(32'h100); do_push(32'h200);
    idle(); push_i = 1'b1; pop_i = 1'b1; push_addr_i = 32'h900; step(); idle();
    n_chk++; if (top_o !== 32'h900 || ckpt_cnt_o !== 3'd2 || ckpt_ptr_o !== 2'd2) begin n_fail++; $display("FAIL pp_nonempty: got top=%h cnt=%0d ptr=%0d want 900 2 2", top_o, ckpt_cnt_o, ckpt_ptr_o); end
    do_pop();
    n_chk++; if (top_o !== 32'h100) begin n_fail++; $display("FAIL pp_below: got %h want %h", top_o, 32'h100); end
    do_reset();
    idle(); push_i = 1'b1; pop_i = 1'b1; push_addr_i = 32'h900; step(); idle();
    n_chk++; if (top_o !== 32'h900 || ckpt_cnt_o !== 3'd1 || ckpt_ptr_o !== 2'd1) begin n_fail++; $display("FAIL pp_empty: got top=%h cnt=%0d ptr=%0d want 900 1 1", top_o, ckpt_cnt_o, ckpt_ptr_o); end
    n_chk++; if (underflow_o !== 1'b0) begin n_fail++; $display("FAIL pp_empty_udf: got %b want 0", underflow_o); end
  endtask

  task automatic test_reset_priority();
    do_reset();
    do_push(32'h11); do_push(32'h22); do_push(32'h33); do_push(32'h44);
    n_chk++; if (top_o !== 32'h44 || ckpt_ptr_o !== 2'd0) begin n_fail++; $display("FAIL prio_setup: got top=%h ptr=%0d want 44 0", top_o, ckpt_ptr_o); end
    idle(); rst = 1'b1; restore_i = 1'b1; restore_ptr_i = 2'd2; restore_cnt_i = 3'd3; restore_top_i = 32'h77;
    push_i = 1'b1; push_addr_i = 32'h88; step(); idle();
    n_chk++; if (top_o !== 32'h0 || top_valid_o !== 1'b0 || ckpt_ptr_o !== 2'd0 || ckpt_cnt_o !== 3'd0) begin n_fail++; $display("FAIL prio_rst: got top=%h valid=%b ptr=%0d cnt=%0d want 0 0 0 0", top_o, top_valid_o, ckpt_ptr_o, ckpt_cnt_o); end
    idle(); restore_i = 1'b1; restore_ptr_i = 2'd3; restore_cnt_i = 3'd0; restore_top_i = 32'h1234; step(); idle();
    n_chk++; if (top_o !== 32'h0 || ckpt_ptr_o !== 2'd3 || top_valid_o !== 1'b0) begin n_fail++; $display("FAIL restore_cnt0: got top=%h ptr=%0d valid=%b want 0 3 0", top_o, ckpt_ptr_o, top_valid_o); end
    idle(); restore_i = 1'b1; restore_ptr_i = 2'd2; restore_cnt_i = 3'd7; restore_top_i = 32'hDEAD; step(); idle();
    n_chk++; if (ckpt_cnt_o !== 3'd4 || ckpt_ptr_o !== 2'd2 || top_o !== 32'hDEAD) begin n_fail++; $display("FAIL restore_clamp: got cnt=%0d ptr=%0d top=%h want 4 2 dead", ckpt_cnt_o, ckpt_ptr_o, top_o); end
    do_push(32'h55);
    n_chk++; if (overflow_o !== 1'b1 || ckpt_cnt_o !== 3'd4) begin n_fail++; $display("FAIL clamp_then_ovf: got ovf=%b cnt=%0d want 1 4", overflow_o, ckpt_cnt_o); end
  endtask

  initial begin
    idle();
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_restore();
    test_push_pop_same();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
